iob_vexriscv_bus_bridge: RTL and testbench
==========================================

IOB_VEXRISCV_BUS_BRIDGE -- requirements
Module: iob_vexriscv_bus_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: address width, both sides.
REQ-002 Parameter DATA_W, default 32: data width, multiple of 8; strobe width DATA_W/8.
REQ-003 Parameter RSP_DEPTH, default 2: response FIFO depth, power of two, >=2.
REQ-004 Parameter ADDR_XOR, default 0 (ADDR_W bits): mask XORed onto every forwarded address.
REQ-005 Parameter WR_RSP, default 0: 1 = writes also return a response entry; 0 = writes return none.
REQ-006 Parameter TIMEOUT, default 0: max REQ-state cycles awaiting iob_ready; 0 disables the timeout.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  clock; all state changes on the rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 cmd_valid  in  1  CPU command valid.
REQ-011 cmd_ready  out  1  command accepted this cycle (cmd_valid && cmd_ready).
REQ-012 cmd_wr  in  1  1 = write, 0 = read.
REQ-013 cmd_address  in  ADDR_W  command byte address.
REQ-014 cmd_data  in  DATA_W  write data.
REQ-015 cmd_mask  in  DATA_W/8  write byte enables.
REQ-016 rsp_valid  out  1  response FIFO head valid.
REQ-017 rsp_ready  in  1  CPU pops head when rsp_valid && rsp_ready.
REQ-018 rsp_data  out  DATA_W  head read data; 0 for write and error entries.
REQ-019 rsp_error  out  1  head entry produced by timeout.
REQ-020 iob_valid  out  1  IOb native request valid.
REQ-021 iob_address  out  ADDR_W  latched cmd_address ^ ADDR_XOR.
REQ-022 iob_wdata  out  DATA_W  latched cmd_data.
REQ-023 iob_wstrb  out  DATA_W/8  latched cmd_mask for writes; all-zero for reads.
REQ-024 iob_ready  in  1  one-cycle completion pulse; iob_rdata valid in that cycle.
REQ-025 iob_rdata  in  DATA_W  read data.
REQ-026 err_cnt  out  8  saturating count of timeouts.

Function
REQ-027 FSM states IDLE, REQ; all outputs registered except cmd_ready and FIFO-head outputs.
REQ-028 IDLE: cmd_ready = (fifo_count < RSP_DEPTH); a pop in the same cycle does not count.
REQ-029 IDLE accept: latch address/data/strobe, go to REQ; iob_valid = 1 from the next cycle (1-cycle latency).
REQ-030 REQ: cmd_ready = 0; iob_valid and iob_address/iob_wdata/iob_wstrb held stable until exit.
REQ-031 REQ with iob_ready = 1: push {iob_rdata, error 0} for a read, or {0, error 0} for a write if WR_RSP = 1; go to IDLE; iob_valid = 0 next cycle.
REQ-032 Pushed entry appears at rsp_valid the next cycle; FIFO is in-order, no overflow possible by REQ-028.
REQ-033 Simultaneous push and pop: fifo_count unchanged, both entries handled correctly; pop on empty ignored.
REQ-034 Timeout (TIMEOUT > 0): counter clears on entering REQ and increments each REQ cycle; if iob_ready is still 0 in the TIMEOUT-th REQ cycle, go to IDLE and push {0, error 1} (writes only if WR_RSP = 1); err_cnt += 1, saturating at 255.
REQ-035 iob_ready in the same cycle as timeout expiry: the normal completion wins; no error.
REQ-036 iob_ready while in IDLE: ignored.
REQ-037 FIFO pointers wrap modulo RSP_DEPTH.

Reset
REQ-038 rst: state IDLE, iob_valid 0, iob_address/iob_wdata/iob_wstrb 0, FIFO emptied (rsp_valid 0), timeout counter 0, err_cnt 0; takes effect next edge, aborting any REQ in progress without a push.

Verification
REQ-039 ADDR_XOR=32'h80000000, read cmd_address 0x00000010 -> iob_address 0x80000010, iob_wstrb 0; iob_ready with rdata 0xDEADBEEF -> next cycle rsp_valid, rsp_data 0xDEADBEEF, rsp_error 0.
REQ-040 WR_RSP=0, write mask 0x3 data 0x1234 -> iob_wstrb 0x3, iob_wdata 0x1234, no rsp_valid; with WR_RSP=1 -> one entry with rsp_data 0.
REQ-041 RSP_DEPTH=2, rsp_ready=0, three reads -> third held (cmd_ready=0) until one pop; order preserved.
REQ-042 TIMEOUT=4, iob_ready never asserted -> iob_valid high exactly 4 cycles, then rsp_error 1, err_cnt 1; repeat with iob_ready in the 4th cycle -> no error.
REQ-043 rst asserted during REQ with 1 FIFO entry -> next cycle iob_valid 0, rsp_valid 0, err_cnt 0, cmd_ready 1.

Source files
------------

// File: rtl/iob_vexriscv_bus_bridge_if.sv
// Bridge bus bundle: CPU command/response channels, IOb native request channel and error count.
// slave = bridge side, master = CPU + IOb environment side.
interface iob_vexriscv_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_W-1:0]     cmd_address;
    logic [DATA_W-1:0]     cmd_data;
    logic [DATA_W/8-1:0]   cmd_mask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_error;
    logic                  iob_valid;
    logic [ADDR_W-1:0]     iob_address;
    logic [DATA_W-1:0]     iob_wdata;
    logic [DATA_W/8-1:0]   iob_wstrb;
    logic                  iob_ready;
    logic [DATA_W-1:0]     iob_rdata;
    logic [7:0]            err_cnt;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask, rsp_ready, iob_ready, iob_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_error, iob_valid, iob_address, iob_wdata, iob_wstrb, err_cnt
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask, rsp_ready, iob_ready, iob_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error, iob_valid, iob_address, iob_wdata, iob_wstrb, err_cnt
    );
endinterface

// File: rtl/iob_vexriscv_bus_bridge.sv
// VexRiscv cmd/rsp to IOb native bridge: one outstanding request, iob_valid 1 cycle after accept, response 1 cycle after iob_ready.
// Backpressure: cmd_ready drops while a request is open or the response FIFO is full; rsp_ready pops the FIFO head.
module iob_vexriscv_bus_bridge #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                RSP_DEPTH = 2,
    parameter logic [ADDR_W-1:0] ADDR_XOR  = '0,
    parameter int                WR_RSP    = 0,
    parameter int                TIMEOUT   = 0
) (
    input logic                      clk,
    input logic                      rst,
    iob_vexriscv_bus_bridge_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [TO_W-1:0]     r_to_cnt;
    logic [7:0]          r_err_cnt;

    logic [DATA_W-1:0]   r_fifo_dat [RSP_DEPTH];
    logic                r_fifo_err [RSP_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_cmd_rdy;
    logic                w_accept;
    logic                w_push;
    logic [DATA_W-1:0]   w_push_dat;
    logic                w_push_err;
    logic                w_timeout;
    logic                w_pop;

    // A pop in the same cycle does not free a slot for a new command.
    assign w_cmd_rdy = (r_state == S_IDLE) && (r_count < DEPTH_C);
    assign w_pop     = (r_count != '0) && bus.rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_push_dat  = '0;
        w_push_err  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && w_cmd_rdy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.iob_ready) begin
                    w_state_nxt = S_IDLE;
                    w_push      = !r_wr || (WR_RSP != 0);
                    w_push_dat  = r_wr ? '0 : bus.iob_rdata;
                end else if ((TIMEOUT != 0) && (r_to_cnt == TO_LAST)) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                    w_push      = !r_wr || (WR_RSP != 0);
                    w_push_err  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_to_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wr     <= bus.cmd_wr;
                r_addr   <= bus.cmd_address ^ ADDR_XOR;
                r_wdata  <= bus.cmd_data;
                r_wstrb  <= bus.cmd_wr ? bus.cmd_mask : '0;
                r_to_cnt <= '0;
            end else if ((r_state == S_REQ) && (TIMEOUT != 0)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Response FIFO; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_dat[r_wr_ptr] <= w_push_dat;
                r_fifo_err[r_wr_ptr] <= w_push_err;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_rdy;
    assign bus.iob_valid   = (r_state == S_REQ);
    assign bus.iob_address = r_addr;
    assign bus.iob_wdata   = r_wdata;
    assign bus.iob_wstrb   = r_wstrb;
    assign bus.rsp_valid   = (r_count != '0);
    assign bus.rsp_data    = r_fifo_dat[r_rd_ptr];
    assign bus.rsp_error   = r_fifo_err[r_rd_ptr];
    assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_iob_vexriscv_bus_bridge.sv
// Bench for the bridge: instance A (XOR mask, write responses, timeout 4, depth 2) against a queue model,
// instance B (defaults-like: no write responses, no timeout, depth 4) with directed checks.
module tb_iob_vexriscv_bus_bridge;
    localparam logic [31:0] XOR_A   = 32'h8000_0000;
    localparam int          DEPTH_A = 2;
    localparam int          TO_A    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iob_vexriscv_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    iob_vexriscv_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    iob_vexriscv_bus_bridge #(.ADDR_W(32), .DATA_W(32), .RSP_DEPTH(DEPTH_A), .ADDR_XOR(XOR_A),
                              .WR_RSP(1), .TIMEOUT(TO_A)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    iob_vexriscv_bus_bridge #(.ADDR_W(32), .DATA_W(32), .RSP_DEPTH(4), .ADDR_XOR(32'h0),
                              .WR_RSP(0), .TIMEOUT(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct packed { logic [31:0] dat; logic err; } rsp_t;

    rsp_t q[$];
    bit   pend_vld;
    rsp_t pend;
    int   model_err;
    bit   rsp_rand;
    int   n_chk;
    int   n_pass;

    // Advance one cycle; update the response queue model for what happened at the edge, then compare the FIFO head.
    task automatic tick();
        bit r, ne;
        r  = ifa.rsp_ready;
        ne = (q.size() != 0);
        @(negedge clk);
        if (rst) begin
            q.delete();
            pend_vld  = 1'b0;
            model_err = 0;
        end else begin
            if (r && ne) void'(q.pop_front());
            if (pend_vld) begin q.push_back(pend); pend_vld = 1'b0; end
        end
        n_chk++;
        if (ifa.rsp_valid !== (q.size() != 0)) $display("FAIL rsp_valid: got %b want %b", ifa.rsp_valid, q.size() != 0);
        else n_pass++;
        if (q.size() != 0) begin
            n_chk++;
            if ({ifa.rsp_data, ifa.rsp_error} !== q[0])
                $display("FAIL rsp_head: got data=%h err=%b want data=%h err=%b", ifa.rsp_data, ifa.rsp_error, q[0].dat, q[0].err);
            else n_pass++;
        end
        if (rsp_rand) ifa.rsp_ready = 1'($urandom);
    endtask

    // One command on A; rdy_at = REQ cycle (1..4) carrying iob_ready, 0 = let it time out.
    task automatic cmd_a(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input int rdy_at, input logic [31:0] rdata);
        int guard;
        guard = 0;
        while (guard < 60) begin
            n_chk++;
            if (ifa.cmd_ready !== (q.size() < DEPTH_A)) $display("FAIL cmd_ready_idle: got %b want %b", ifa.cmd_ready, q.size() < DEPTH_A);
            else n_pass++;
            if (ifa.cmd_ready) break;
            tick();
            guard++;
        end
        if (guard == 60) begin n_chk++; $display("FAIL cmd_accept: got no cmd_ready want ready within 60 cycles"); end
        ifa.cmd_valid = 1'b1; ifa.cmd_wr = wr; ifa.cmd_address = addr; ifa.cmd_data = data; ifa.cmd_mask = mask;
        tick();
        ifa.cmd_valid = 1'b0; ifa.cmd_wr = 1'($urandom); ifa.cmd_address = $urandom;
        ifa.cmd_data = $urandom; ifa.cmd_mask = 4'($urandom);
        for (int k = 1; k <= TO_A; k++) begin
            n_chk++;
            if ({ifa.iob_valid, ifa.cmd_ready, ifa.iob_address, ifa.iob_wdata, ifa.iob_wstrb} !==
                {1'b1, 1'b0, addr ^ XOR_A, data, wr ? mask : 4'h0})
                $display("FAIL iob_req cyc%0d: got v=%b rdy=%b a=%h d=%h s=%h want v=1 rdy=0 a=%h d=%h s=%h", k,
                         ifa.iob_valid, ifa.cmd_ready, ifa.iob_address, ifa.iob_wdata, ifa.iob_wstrb,
                         addr ^ XOR_A, data, wr ? mask : 4'h0);
            else n_pass++;
            if (k == rdy_at) begin
                ifa.iob_ready = 1'b1; ifa.iob_rdata = rdata;
                pend_vld = 1'b1; pend.dat = wr ? 32'h0 : rdata; pend.err = 1'b0;
                tick();
                ifa.iob_ready = 1'b0; ifa.iob_rdata = $urandom;
                break;
            end else if (k == TO_A) begin
                pend_vld = 1'b1; pend.dat = 32'h0; pend.err = 1'b1;
                if (model_err < 255) model_err++;
                tick();
            end else begin
                tick();
            end
        end
        n_chk++;
        if (ifa.iob_valid !== 1'b0) $display("FAIL iob_valid_exit: got %b want 0", ifa.iob_valid); else n_pass++;
        n_chk++;
        if (ifa.err_cnt !== 8'(model_err)) $display("FAIL err_cnt: got %0d want %0d", ifa.err_cnt, model_err); else n_pass++;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        ifa.rsp_ready = 1'b1;
        while (q.size() != 0 && guard < 20) begin tick(); guard++; end
        ifa.rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_chk++;
        if ({ifa.iob_valid, ifa.iob_address, ifa.iob_wdata, ifa.iob_wstrb, ifa.err_cnt, ifa.cmd_ready} !== {1'b0, 32'h0, 32'h0, 4'h0, 8'h0, 1'b1})
            $display("FAIL reset_a: got v=%b a=%h d=%h s=%h e=%0d rdy=%b want all 0, rdy=1", ifa.iob_valid, ifa.iob_address,
                     ifa.iob_wdata, ifa.iob_wstrb, ifa.err_cnt, ifa.cmd_ready);
        else n_pass++;
        n_chk++;
        if ({ifb.iob_valid, ifb.rsp_valid, ifb.err_cnt, ifb.cmd_ready} !== {1'b0, 1'b0, 8'h0, 1'b1})
            $display("FAIL reset_b: got v=%b rv=%b e=%0d rdy=%b want 0 0 0 1", ifb.iob_valid, ifb.rsp_valid, ifb.err_cnt, ifb.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_read_xor();
        rsp_rand = 1'b0; ifa.rsp_ready = 1'b0;
        cmd_a(1'b0, 32'h0000_0010, $urandom, 4'hF, 1, 32'hDEAD_BEEF);
        n_chk++;
        if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error} !== {1'b1, 32'hDEAD_BEEF, 1'b0})
            $display("FAIL read_rsp: got v=%b d=%h e=%b want 1 deadbeef 0", ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error);
        else n_pass++;
        drain();
    endtask

    task automatic test_write_rsp();
        cmd_a(1'b1, $urandom, 32'h0000_1234, 4'h3, 2, 32'hA5A5_5A5A);
        n_chk++;
        if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL write_rsp: got v=%b d=%h e=%b want 1 0 0", ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error);
        else n_pass++;
        drain();
    endtask

    task automatic test_no_wr_rsp_no_timeout();
        n_chk++;
        if (ifb.cmd_ready !== 1'b1) $display("FAIL b_cmd_ready: got %b want 1", ifb.cmd_ready); else n_pass++;
        ifb.cmd_valid = 1'b1; ifb.cmd_wr = 1'b1; ifb.cmd_address = 32'h40; ifb.cmd_data = 32'h1234; ifb.cmd_mask = 4'h3;
        tick();
        ifb.cmd_valid = 1'b0; ifb.cmd_data = 32'h0; ifb.cmd_mask = 4'h0;
        n_chk++;
        if ({ifb.iob_valid, ifb.iob_address, ifb.iob_wdata, ifb.iob_wstrb} !== {1'b1, 32'h40, 32'h1234, 4'h3})
            $display("FAIL b_write_req: got v=%b a=%h d=%h s=%h want 1 40 1234 3", ifb.iob_valid, ifb.iob_address, ifb.iob_wdata, ifb.iob_wstrb);
        else n_pass++;
        ifb.iob_ready = 1'b1; ifb.iob_rdata = 32'hFFFF_FFFF;
        tick();
        ifb.iob_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({ifb.iob_valid, ifb.rsp_valid} !== 2'b00) $display("FAIL b_write_norsp: got v=%b rv=%b want 0 0", ifb.iob_valid, ifb.rsp_valid);
            else n_pass++;
            tick();
        end
        ifb.cmd_valid = 1'b1; ifb.cmd_wr = 1'b0; ifb.cmd_address = 32'h80;
        tick();
        ifb.cmd_valid = 1'b0;
        repeat (10) tick();
        n_chk++;
        if ({ifb.iob_valid, ifb.rsp_valid, ifb.err_cnt, ifb.iob_wstrb} !== {1'b1, 1'b0, 8'h0, 4'h0})
            $display("FAIL b_no_timeout: got v=%b rv=%b e=%0d s=%h want 1 0 0 0", ifb.iob_valid, ifb.rsp_valid, ifb.err_cnt, ifb.iob_wstrb);
        else n_pass++;
        ifb.iob_ready = 1'b1; ifb.iob_rdata = 32'hCAFE_F00D;
        tick();
        ifb.iob_ready = 1'b0;
        n_chk++;
        if ({ifb.rsp_valid, ifb.rsp_data, ifb.rsp_error} !== {1'b1, 32'hCAFE_F00D, 1'b0})
            $display("FAIL b_read_rsp: got v=%b d=%h e=%b want 1 cafef00d 0", ifb.rsp_valid, ifb.rsp_data, ifb.rsp_error);
        else n_pass++;
        ifb.rsp_ready = 1'b1;
        tick();
        ifb.rsp_ready = 1'b0;
        n_chk++;
        if (ifb.rsp_valid !== 1'b0) $display("FAIL b_pop: got %b want 0", ifb.rsp_valid); else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [31:0] r1, r2, r3;
        r1 = $urandom; r2 = $urandom; r3 = $urandom;
        rsp_rand = 1'b0; ifa.rsp_ready = 1'b0;
        cmd_a(1'b0, $urandom, $urandom, 4'h0, 1, r1);
        cmd_a(1'b0, $urandom, $urandom, 4'h0, 1, r2);
        ifa.cmd_valid = 1'b1; ifa.cmd_wr = 1'b0; ifa.cmd_address = $urandom;
        repeat (3) begin
            n_chk++;
            if ({ifa.cmd_ready, ifa.iob_valid} !== 2'b00) $display("FAIL full_hold: got rdy=%b v=%b want 0 0", ifa.cmd_ready, ifa.iob_valid);
            else n_pass++;
            tick();
        end
        ifa.cmd_valid = 1'b0;
        ifa.rsp_ready = 1'b1;
        n_chk++;
        if (ifa.cmd_ready !== 1'b0) $display("FAIL pop_same_cycle: got %b want 0", ifa.cmd_ready); else n_pass++;
        tick();
        ifa.rsp_ready = 1'b0;
        n_chk++;
        if (ifa.rsp_data !== r2) $display("FAIL order_2nd: got %h want %h", ifa.rsp_data, r2); else n_pass++;
        cmd_a(1'b0, $urandom, $urandom, 4'h0, 1, r3);
        ifa.rsp_ready = 1'b1;
        tick();
        n_chk++;
        if (ifa.rsp_data !== r3) $display("FAIL order_3rd: got %h want %h", ifa.rsp_data, r3); else n_pass++;
        drain();
    endtask

    task automatic test_timeout();
        int e0;
        e0 = model_err;
        cmd_a(1'b0, $urandom, $urandom, 4'h0, 0, 32'h0);
        n_chk++;
        if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error, ifa.err_cnt} !== {1'b1, 32'h0, 1'b1, 8'(e0 + 1)})
            $display("FAIL timeout_rsp: got v=%b d=%h e=%b cnt=%0d want 1 0 1 %0d", ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error, ifa.err_cnt, e0 + 1);
        else n_pass++;
        drain();
        cmd_a(1'b0, $urandom, $urandom, 4'h0, 4, 32'h1357_9BDF);
        n_chk++;
        if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error, ifa.err_cnt} !== {1'b1, 32'h1357_9BDF, 1'b0, 8'(e0 + 1)})
            $display("FAIL ready_at_expiry: got v=%b d=%h e=%b cnt=%0d want 1 13579bdf 0 %0d", ifa.rsp_valid, ifa.rsp_data, ifa.rsp_error, ifa.err_cnt, e0 + 1);
        else n_pass++;
        drain();
        cmd_a(1'b1, $urandom, $urandom, 4'hF, 0, 32'h0);
        drain();
    endtask

    task automatic test_idle_ready();
        repeat (3) begin
            ifa.iob_ready = 1'b1; ifa.iob_rdata = $urandom;
            tick();
            n_chk++;
            if ({ifa.iob_valid, ifa.cmd_ready} !== 2'b01) $display("FAIL idle_ready: got v=%b rdy=%b want 0 1", ifa.iob_valid, ifa.cmd_ready);
            else n_pass++;
        end
        ifa.iob_ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        rsp_rand = 1'b1;
        for (int i = 0; i < 40; i++)
            cmd_a(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom);
        rsp_rand = 1'b0;
        drain();
    endtask

    task automatic test_reset_in_req();
        rsp_rand = 1'b0; ifa.rsp_ready = 1'b0;
        cmd_a(1'b0, $urandom, $urandom, 4'h0, 0, 32'h0);
        ifa.cmd_valid = 1'b1; ifa.cmd_wr = 1'b0; ifa.cmd_address = $urandom;
        tick();
        ifa.cmd_valid = 1'b0;
        tick();
        n_chk++;
        if ({ifa.iob_valid, ifa.rsp_valid} !== 2'b11 || ifa.err_cnt === 8'h0)
            $display("FAIL pre_reset: got v=%b rv=%b cnt=%0d want 1 1 nonzero", ifa.iob_valid, ifa.rsp_valid, ifa.err_cnt);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({ifa.iob_valid, ifa.rsp_valid, ifa.err_cnt, ifa.cmd_ready} !== {1'b0, 1'b0, 8'h0, 1'b1})
            $display("FAIL reset_in_req: got v=%b rv=%b cnt=%0d rdy=%b want 0 0 0 1", ifa.iob_valid, ifa.rsp_valid, ifa.err_cnt, ifa.cmd_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_err_sat();
        rsp_rand = 1'b1;
        for (int i = 0; i < 258; i++)
            cmd_a(1'($urandom), $urandom, $urandom, 4'($urandom), 0, 32'h0);
        n_chk++;
        if (ifa.err_cnt !== 8'hFF) $display("FAIL err_sat: got %0d want 255", ifa.err_cnt); else n_pass++;
        rsp_rand = 1'b0;
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; model_err = 0; pend_vld = 1'b0; rsp_rand = 1'b0;
        rst = 1'b1;
        ifa.cmd_valid = 1'b0; ifa.cmd_wr = 1'b0; ifa.cmd_address = '0; ifa.cmd_data = '0; ifa.cmd_mask = '0;
        ifa.rsp_ready = 1'b0; ifa.iob_ready = 1'b0; ifa.iob_rdata = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_wr = 1'b0; ifb.cmd_address = '0; ifb.cmd_data = '0; ifb.cmd_mask = '0;
        ifb.rsp_ready = 1'b0; ifb.iob_ready = 1'b0; ifb.iob_rdata = '0;
        test_reset();
        test_read_xor();
        test_write_rsp();
        test_no_wr_rsp_no_timeout();
        test_fifo_full();
        test_timeout();
        test_idle_ready();
        test_random();
        test_reset_in_req();
        test_err_sat();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
